// File: rtl/present_inv_round.sv
// One PRESENT decryption round: addRoundKey, inverse pLayer, then an inverse
// sBoxLayer applied NIBBLES_PER_CYCLE nibbles per clock, with a valid/ready handshake.
module present_inv_round #(
  parameter int NIBBLES_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [63:0] in_key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, PROC, DONE} fsm_t;

  localparam logic [4:0] STEP = 5'(NIBBLES_PER_CYCLE);
  localparam logic [4:0] LAST = 5'd16;

  fsm_t        st;
  fsm_t        st_nxt;
  logic [4:0]  cnt;
  logic [63:0] blk;
  logic [63:0] blk_sub;
  logic        last_step;

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
      4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
      4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
      4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
    endcase
    return y;
  endfunction

  function automatic logic [63:0] inv_player(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 63; i++) y[i] = x[(16 * i) % 63];
    y[63] = x[63];
    return y;
  endfunction

  // Substitute only the nibble window [cnt, cnt+STEP) this cycle.
  always_comb begin
    blk_sub = blk;
    for (int j = 0; j < 16; j++) begin
      if ((5'(j) >= cnt) && (5'(j) < cnt + STEP))
        blk_sub[4*j +: 4] = inv_sbox(blk[4*j +: 4]);
    end
  end

  assign last_step = ((cnt + STEP) == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:    if (in_valid)  st_nxt = PROC;
      PROC:    if (last_step) st_nxt = DONE;
      DONE:    if (out_ready) st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (st == IDLE);
    out_valid = (st == DONE);
    busy      = (st != IDLE);
    out_data  = blk;
  end

  // Datapath: key mix + bit permutation on accept, then incremental substitution.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk <= '0;
      cnt <= '0;
    end else begin
      case (st)
        IDLE: if (in_valid) begin
          blk <= inv_player(in_data ^ in_key);
          cnt <= '0;
        end
        PROC: begin
          blk <= blk_sub;
          cnt <= cnt + STEP;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/present_inv_round.md
PRESENT_INV_ROUND -- requirements
Module: present_inv_round

Interface
REQ-001 The module SHALL have parameter NIBBLES_PER_CYCLE, default 1, meaning inverse S-boxes applied per processing cycle; legal values are 1, 2, 4, 8 and 16.
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 The module SHALL have port in_valid, input, 1 bit, meaning the upstream block offers in_data/in_key.
REQ-005 The module SHALL have port in_ready, output, 1 bit, meaning the module can accept a block.
REQ-006 The module SHALL have port in_data, input, 64 bits, the cipher state entering the decryption round.
REQ-007 The module SHALL have port in_key, input, 64 bits, the round key for this round.
REQ-008 The module SHALL have port out_valid, output, 1 bit, meaning out_data holds a finished result.
REQ-009 The module SHALL have port out_ready, input, 1 bit, meaning downstream accepts out_data.
REQ-010 The module SHALL have port out_data, output, 64 bits, the round result.
REQ-011 The module SHALL have port busy, output, 1 bit, high in states PROC and DONE.

Function
REQ-012 The module SHALL implement one PRESENT decryption round: addRoundKey, then inverse pLayer, then inverse sBoxLayer.
REQ-013 The inverse S-box SHALL map nibble values 0..F to 5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A respectively.
REQ-014 The inverse pLayer SHALL set output bit i = input bit ((16*i) mod 63) for i = 0..62, and output bit 63 = input bit 63.
REQ-015 The FSM SHALL have states IDLE, PROC and DONE.
REQ-016 In IDLE, in_ready SHALL be 1; all other states SHALL drive in_ready 0.
REQ-017 On an edge with in_valid=1 in IDLE, the module SHALL register state = invP(in_data XOR in_key), clear the nibble counter and enter PROC; in_data and in_key are sampled only on that edge.
REQ-018 In PROC, each edge SHALL replace nibbles [cnt .. cnt+NIBBLES_PER_CYCLE-1] of state with their inverse S-box values, nibble 0 being bits 3:0, and advance cnt by NIBBLES_PER_CYCLE.
REQ-019 The counter SHALL be 5 bits wide; when the edge processes the last nibble (cnt+NIBBLES_PER_CYCLE = 16), the FSM SHALL enter DONE; cnt never wraps inside PROC.
REQ-020 Latency SHALL be exactly 16/NIBBLES_PER_CYCLE edges from the accepting edge to out_valid=1.
REQ-021 In DONE, out_valid SHALL be 1 and out_data SHALL equal state, held stable until out_ready=1.
REQ-022 On an edge in DONE with out_ready=1, the FSM SHALL return to IDLE and drop out_valid; in_ready is 1 in the following cycle; no same-edge accept of a new block.
REQ-023 out_ready SHALL be ignored outside DONE; in_valid SHALL be ignored outside IDLE.
REQ-024 out_valid SHALL be 0 in IDLE and PROC; out_data SHALL hold the last state register value, with no requirement on it outside DONE.

Reset
REQ-025 rst_n=0 SHALL immediately, without a clock, force state IDLE, in_ready=1, out_valid=0, busy=0, cnt=0 and out_data=0.
REQ-026 Reset asserted during PROC or DONE SHALL abort the block with no output; after release the first accepted block is processed normally.
REQ-027 Release of rst_n SHALL take effect on the first rising clk edge where rst_n=1; no accept occurs on the release edge if rst_n is still 0.

Verification
REQ-028 in_data=0, in_key=0, out_ready=1, NIBBLES_PER_CYCLE=1 -> out_valid rises 16 edges after accept; out_data=0x5555555555555555.
REQ-029 in_data=0xFFFFFFFFFFFFFFFF, in_key=0 -> out_data=0xAAAAAAAAAAAAAAAA; same data with in_key=0xFFFFFFFFFFFFFFFF -> 0x5555555555555555.
REQ-030 in_data=0x1, in_key=0 -> 0x555555555555555E; in_data=0x2, in_key=0 -> 0x55555555555555E5 (checks inverse pLayer).
REQ-031 out_ready held 0 for 5 cycles in DONE -> out_valid and out_data stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-032 rst_n pulsed low mid-PROC -> outputs reach reset values without a clock edge; a subsequent block in_data=0 yields 0x5555555555555555.
REQ-033 Repeat REQ-028..REQ-030 with NIBBLES_PER_CYCLE=4 and 16 -> same out_data, latency 4 and 1 edges.
